// File: rtl/word_packer.sv
// Packs WORDS narrow valid-ready words into one zero-padded wide block; out_valid rises the cycle after the closing word.
// Backpressure: in_ready is low for the whole HOLD state, so a stalled consumer stalls the producer with no loss.
module word_packer #(
  parameter int IN_W  = 32,
  parameter int WORDS = 16,
  parameter int CNT_W = $clog2(WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sync_rst,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_last,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [IN_W*WORDS-1:0] out_data,
  output logic                  out_last,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IDX_W = $clog2(WORDS);

  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]                  state;
  logic [CNT_W-1:0]            cnt;
  logic [WORDS-1:0][IN_W-1:0]  blk;
  logic                        in_shake;
  logic                        out_shake;
  logic                        closing;

  // Handshake qualifiers depend only on state and the enables, never on valid/ready.
  assign in_ready  = en & ~sync_rst & ~rst & (state == FILL);
  assign out_valid = en & (state == HOLD);
  assign in_shake  = in_valid & in_ready;
  assign out_shake = out_valid & out_ready;
  assign closing   = in_last | (cnt == CNT_W'(WORDS - 1));
  assign out_data  = blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      cnt       <= '0;
      blk       <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else if (sync_rst) begin
      state     <= FILL;
      cnt       <= '0;
      blk       <= '0;
      out_last  <= 1'b0;
      out_count <= '0;
    end else if (en) begin
      if (state == FILL) begin
        if (in_shake) begin
          blk[cnt[IDX_W-1:0]] <= in_data;
          if (closing) begin
            state     <= HOLD;
            out_count <= cnt + CNT_W'(1);
            out_last  <= in_last;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
      end else if (out_shake) begin
        // Clearing here gives the zero padding for the next short block.
        state     <= FILL;
        blk       <= '0;
        out_last  <= 1'b0;
        out_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_word_packer.sv
// Randomised and directed bench for word_packer against a queue-based block model.
module tb_word_packer;

  localparam int IN_W  = 32;
  localparam int WORDS = 16;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int DW    = IN_W * WORDS;

  logic              clk = 1'b0;
  logic              rst, en, sync_rst;
  logic [IN_W-1:0]   in_data;
  logic              in_last, in_valid, in_ready;
  logic [DW-1:0]     out_data;
  logic              out_last, out_valid, out_ready;
  logic [CNT_W-1:0]  out_count;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            cnt;
    bit            last;
  } blk_t;

  blk_t            exp_q[$];
  logic [IN_W-1:0] part[$];

  word_packer #(.IN_W(IN_W), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .sync_rst(sync_rst),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a block exists once WORDS words or a last word have been accepted;
  // while one is pending the packer presents it and refuses input.
  always @(negedge clk) begin
    bit   holding, exp_rdy, exp_vld;
    blk_t b;
    if (rst) begin
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_last", out_last, 0);
      exp_q.delete();
      part.delete();
    end else begin
      holding = (exp_q.size() > 0);
      exp_rdy = en && !sync_rst && !holding;
      exp_vld = en && holding;
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, exp_vld);
      if (holding) begin
        chk("blk_data", out_data, exp_q[0].d);
        chk("blk_count", out_count, exp_q[0].cnt);
        chk("blk_last", out_last, exp_q[0].last);
      end else begin
        chk("fill_count", out_count, 0);
        chk("fill_last", out_last, 0);
      end
      if (sync_rst) begin
        exp_q.delete();
        part.delete();
      end else begin
        if (exp_vld && out_ready) void'(exp_q.pop_front());
        if (exp_rdy && in_valid) begin
          part.push_back(in_data);
          if (part.size() == WORDS || in_last) begin
            b.d = '0;
            for (int k = 0; k < part.size(); k++) b.d[k*IN_W +: IN_W] = part[k];
            b.cnt  = part.size();
            b.last = in_last;
            exp_q.push_back(b);
            part.delete();
          end
        end
      end
    end
  end

  task automatic send(input logic [IN_W-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
  endtask

  task automatic rst_test(input bit use_sync);
    logic [DW-1:0] lit;
    lit = 512'h00000222_00000111;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(32'h900 + i, 1'b0);
    in_valid = 1'b0;
    if (use_sync) sync_rst = 1'b1; else rst = 1'b1;
    tick();
    sync_rst = 1'b0;
    rst      = 1'b0;
    send(32'h111, 1'b0);
    send(32'h222, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("rst_fill_count", out_count, 2);
    chk("rst_fill_data", out_data, lit);
    tick();
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    logic [DW-1:0] lit_full, lit_short, exp_d;
    lit_full  = 512'h0000000f_0000000e_0000000d_0000000c_0000000b_0000000a_00000009_00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
    lit_short = 512'h0000000c_0000000b_0000000a;

    rst = 1'b1; en = 1'b1; sync_rst = 1'b0;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_data", out_data, 0);
    tick();
    rst = 1'b0;

    // Full block, back to back, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      in_valid = 1'b1; in_data = i; in_last = 1'b0;
      if (i == WORDS - 1) begin
        @(negedge clk);
        chk("full_pre_close_valid", out_valid, 0);
      end
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_valid", out_valid, 1);
    chk("full_in_ready_low", in_ready, 0);
    chk("full_data", out_data, lit_full);
    chk("full_count", out_count, 16);
    chk("full_last", out_last, 0);
    tick();
    @(negedge clk);
    chk("full_ready_back", in_ready, 1);

    // Short final block, then held under backpressure.
    out_ready = 1'b0;
    send(32'hA, 1'b0);
    send(32'hB, 1'b0);
    send(32'hC, 1'b1);
    in_valid = 1'b1; in_data = 32'hDEAD; in_last = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("short_data", out_data, lit_short);
      chk("short_count", out_count, 3);
      chk("short_last", out_last, 1);
    end
    tick();
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_zero", out_data, 0);

    // Last word coincides with the block boundary.
    for (int i = 0; i < WORDS; i++) send($urandom, i == WORDS - 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bnd_count", out_count, 16);
    chk("bnd_last", out_last, 1);
    tick();
    out_ready = 1'b0;
    send(32'h5A5A, 1'b1);
    in_valid = 1'b0;
    exp_d = '0;
    exp_d[IN_W-1:0] = 32'h5A5A;
    @(negedge clk);
    chk("first_last_count", out_count, 1);
    chk("first_last_data", out_data, exp_d);
    out_ready = 1'b1;
    tick();
    tick();

    rst_test(1'b0);
    rst_test(1'b1);

    // Enable gating mid-block.
    out_ready = 1'b0;
    exp_d = '0;
    for (int i = 0; i < 7; i++) begin
      exp_d[i*IN_W +: IN_W] = 100 + i;
      send(100 + i, 1'b0);
    end
    en = 1'b0; in_valid = 1'b1; in_data = 32'hBAD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("en_low_ready", in_ready, 0);
      tick();
    end
    en = 1'b1;
    for (int i = 7; i < WORDS; i++) begin
      exp_d[i*IN_W +: IN_W] = 100 + i;
      send(100 + i, 1'b0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("en_count", out_count, 16);
    chk("en_data", out_data, exp_d);
    out_ready = 1'b1;
    tick();

    // Random traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      sync_rst  = ($urandom_range(0, 149) == 0);
      en        = ($urandom_range(0, 9) != 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_last   = ($urandom_range(0, 4) == 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b0; sync_rst = 1'b0; in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/word_packer.md
# word_packer

Accumulates a stream of narrow valid-ready words (data + last) into one wide block and emits the block on a valid-ready output. It sits directly downstream of the accelerator's input FIFO and consumes the FIFO's out_data/out_last stream. It presents full-width blocks (e.g. 16 x 32-bit = 512-bit) to the accelerator core. A short final block is zero-padded and carries a word count.

## Interface
- IN_W, 32: width of one input word.
- WORDS, 16: input words per output block (>= 2).
- CNT_W, $clog2(WORDS+1): width of word counter and out_count.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  block enable; low freezes all state.
- sync_rst  in  1  synchronous, localised reset; same effect as rst, applied at the clock edge.
- in_data  in  IN_W  input word.
- in_last  in  1  marks the final word of a message.
- in_valid  in  1  input word valid.
- in_ready  out  1  packer can accept a word.
- out_data  out  IN_W*WORDS  packed block; word i at bits [i*IN_W +: IN_W].
- out_last  out  1  block contains the final word of a message.
- out_count  out  CNT_W  number of valid words in the block (1..WORDS).
- out_valid  out  1  block valid.
- out_ready  in  1  consumer accepts block.

## Operation
- Handshakes:
  - in_shake = in_valid & in_ready.
  - out_shake = out_valid & out_ready.
- State machine with two states.
  - FILL: collecting words.
  - HOLD: presenting a block.
- Registered state: state, word counter cnt (CNT_W bits), block buffer, out_last, out_count.
- FILL:
  - in_ready = en & ~sync_rst; out_valid = 0.
  - On in_shake: in_data is written to word slot cnt.
  - If cnt == WORDS-1 or in_last = 1:
    - go to HOLD;
    - out_count <= cnt+1;
    - out_last <= in_last;
    - cnt <= 0.
  - Otherwise cnt <= cnt+1.
- HOLD:
  - in_ready = 0; out_valid = en.
  - out_data, out_last and out_count are held stable.
  - On out_shake: go to FILL, clear the buffer to all zeros, clear out_last to 0 and out_count to 0.
- Zero padding: the buffer is all-zero on entry to FILL, so slots not written before in_last stay 0.
- en low:
  - in_ready = 0 and out_valid = 0 (combinational gating);
  - state, cnt and buffer are retained;
  - operation resumes exactly where it stopped when en returns high.
- Reset (rst async, or sync_rst at the edge):
  - state = FILL, cnt = 0, buffer = 0, out_last = 0, out_count = 0;
  - any partially filled block is discarded.
- Reset values of outputs:
  - in_ready = 0 while rst is high, then en-gated;
  - out_valid = 0; out_data = 0; out_last = 0; out_count = 0.
- Width rules: cnt never exceeds WORDS-1 in FILL; out_count = WORDS for a full block.

## Timing
- in_ready and out_valid are combinational from state, en and sync_rst only.
  - No combinational path from in_valid to in_ready.
  - No combinational path from out_ready to out_valid, or between out_ready and in_ready.
- Latency: out_valid rises in the cycle after the handshake of the closing word (the WORDS-th word, or the in_last word).
- Throughput:
  - a full block takes WORDS input cycles plus at least 1 HOLD cycle;
  - in_ready returns in the cycle after out_shake.
- in_last on the WORDS-th word closes one block with out_count = WORDS and out_last = 1. No empty trailing block is produced.
- in_last on the first word yields out_count = 1.
- In HOLD, out_data, out_last and out_count are stable until out_shake, for any duration of out_ready = 0.
- rst asserted mid-HOLD:
  - out_valid drops immediately (async);
  - the block is lost and not replayed.

## Test plan
- Full block: defaults, words 0x0..0xF sent back-to-back with in_last = 0 and out_ready = 1.
  - Expected: out_valid one cycle after the 16th handshake, word i = i, out_count = 16, out_last = 0, in_ready low for exactly 1 cycle.
- Short final block: words 0xA, 0xB, 0xC with in_last on 0xC.
  - Expected: out_count = 3, out_last = 1, word0..2 = A,B,C, words 3..15 = 0.
- Backpressure: complete a block, then hold out_ready = 0 for 10 cycles with in_valid = 1.
  - Expected: out_valid stays 1 and outputs stay stable, in_ready stays 0, no words are accepted.
  - Then out_ready = 1: the next cycle is in FILL with in_ready = 1 and the buffer all zero.
- Last on boundary: 16 words with in_last on the 16th.
  - Expected: one block with out_count = 16 and out_last = 1, followed by FILL with cnt = 0.
- Reset mid-fill: 5 words accepted, then a 1-cycle rst pulse (repeat using sync_rst), then 2 words with in_last.
  - Expected: out_count = 2, word0..1 = the new words, all other words 0.
- Enable gating: en = 0 for 4 cycles after 7 words, in_valid held 1.
  - Expected: in_ready = 0 and no words accepted.
  - After en = 1, 9 more words complete a 16-word block in order.
